// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Time-shares one external combinational ALU between two requesters.
// A round-robin arbiter picks a requester in IDLE. Its operands are latched
// into the alu_* registers, and the ALU is given one EXEC cycle. The result is
// then registered and returned on a single response channel, tagged with the
// requester ID. An illegal opcode skips EXEC and leaves the alu_* registers
// untouched. Its error response is produced directly.
//
// Ports
//   clock, reset_n          : clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready : requester N handshake (ready only in IDLE, winner)
//   reqN_opcode/_a/_b/_shamt: requester N operation fields
//   alu_opcode/_a/_b/_shamt : registered operands to the external ALU
//   alu_result, alu_ovf     : combinational ALU outputs, captured in EXEC
//   resp_valid / resp_ready : response handshake
//   resp_id/_data/_ovf/_err : registered response fields
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int DW      = 32,
  parameter int NUM_OPS = 6
) (
  input  logic          clock,
  input  logic          reset_n,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [4:0]    req0_opcode,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [4:0]    req0_shamt,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [4:0]    req1_opcode,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [4:0]    req1_shamt,

  output logic [4:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_shamt,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_ovf,

  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_id,
  output logic [DW-1:0] resp_data,
  output logic          resp_ovf,
  output logic          resp_err
);

  // Opcode legality bound, sized to the opcode field for a width-matched compare.
  localparam logic [4:0] LP_NUM_OPS = 5'(NUM_OPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic          r_last_grant;
  logic [4:0]    r_alu_opcode;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [4:0]    r_alu_shamt;
  logic          r_resp_id;
  logic [DW-1:0] r_resp_data;
  logic          r_resp_ovf;
  logic          r_resp_err;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t        w_next_state;
  logic          w_any_req;
  logic          w_win_id;
  logic          w_accept;
  logic          w_legal;
  logic [4:0]    w_sel_opcode;
  logic [DW-1:0] w_sel_a;
  logic [DW-1:0] w_sel_b;
  logic [4:0]    w_sel_shamt;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // A lone requester always wins. On a tie, the requester that did not win
  // last time wins. r_last_grant resets to 1, so requester 0 wins the first
  // tie after reset.
  // ---------------------------------------------------------------------------
  assign w_any_req = req0_valid | req1_valid;
  assign w_win_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  // Operand mux in front of the latches. The mux is meaningful only when
  // w_accept is high.
  assign w_sel_opcode = w_win_id ? req1_opcode : req0_opcode;
  assign w_sel_a      = w_win_id ? req1_a      : req0_a;
  assign w_sel_b      = w_win_id ? req1_b      : req0_b;
  assign w_sel_shamt  = w_win_id ? req1_shamt  : req0_shamt;

  assign w_legal = (w_sel_opcode < LP_NUM_OPS);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) assignments. Every flop
      //       then samples pre-edge values, independent of block ordering.
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case. This
    //       ensures that no path leaves a signal unassigned, which would infer
    //       a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_accept   = 1'b1;
          req0_ready = ~w_win_id;
          req1_ready =  w_win_id;
          // An illegal opcode never reaches the ALU. Its error response is
          // ready one cycle earlier than a legal result.
          w_next_state = w_legal ? S_EXEC : S_RESP;
        end
      end

      S_EXEC: begin
        w_next_state = S_RESP;
      end

      S_RESP: begin
        // No new request is accepted here. The next arbitration happens only
        // after a cycle back in IDLE.
        if (resp_ready) begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: arbitration history, ALU operand latches, response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_shamt  <= '0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_ovf   <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_win_id;
        r_resp_id    <= w_win_id;
        if (w_legal) begin
          r_alu_opcode <= w_sel_opcode;
          r_alu_a      <= w_sel_a;
          r_alu_b      <= w_sel_b;
          r_alu_shamt  <= w_sel_shamt;
        end else begin
          // The ALU latches keep the previous operation. Only the response is
          // written, with an error and a zero result.
          r_resp_data <= '0;
          r_resp_ovf  <= 1'b0;
          r_resp_err  <= 1'b1;
        end
      end

      if (r_state == S_EXEC) begin
        r_resp_data <= alu_result;
        r_resp_ovf  <= alu_ovf;
        r_resp_err  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // resp_valid is a decode of the state register, so it is glitch-free. It is
  // low during reset, and an operation interrupted by reset never responds.
  // ---------------------------------------------------------------------------
  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_ovf   = r_resp_ovf;
  assign resp_err   = r_resp_err;

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_shamt  = r_alu_shamt;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_ready_onehot : assert property (
    @(posedge clock) disable iff (!reset_n)
      !(req0_ready && req1_ready));

  a_resp_hold : assert property (
    @(posedge clock) disable iff (!reset_n)
      (resp_valid && !resp_ready) |=>
        (resp_valid && $stable(resp_id) && $stable(resp_data) &&
         $stable(resp_ovf) && $stable(resp_err)));

endmodule
